// File: rtl/axi_ring_wr_dma.sv
// axi_ring_wr_dma
//   AXI3 write-burst master that drains a sample stream into a ring buffer
//   in DDR. Samples land in a first-word-fall-through FIFO; whenever at least
//   one full burst is buffered, the FSM issues an INCR burst at base+acnt.
//   After the write response, acnt advances by one burst and wraps at size.
//   A rising edge on en restarts the ring at offset 0 and clears the FIFO,
//   the counters and the sticky error flag.
// Ports
//   clk, nrst              clock, asynchronous active-low reset
//   en                     capture enable (rising edge = restart)
//   base, size             ring base byte address and ring size in bytes
//   s_data/s_valid/s_ready sample input
//   aw*, w*, b*            AXI3 write address / data / response channels
//   acnt, bcnt             next-burst byte offset, ring wrap count
//   ovf_cnt                dropped samples (saturating)
//   resp_err               sticky non-OKAY write response since last start
//   busy                   burst in flight
module axi_ring_wr_dma #(
    parameter int          DW         = 32,
    parameter int          BURST      = 16,
    parameter int          FIFO_DEPTH = 64,
    parameter logic [5:0]  AXI_ID     = 6'd0
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic [31:0]     base,
    input  logic [23:0]     size,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [5:0]      awid,
    output logic            awvalid,
    input  logic            awready,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic [23:0]     acnt,
    output logic [31:0]     bcnt,
    output logic [15:0]     ovf_cnt,
    output logic            resp_err,
    output logic            busy
);

    // state  | meaning
    // IDLE   | waiting for en and a full burst in the FIFO
    // AW     | address phase, awvalid held until awready
    // W      | streaming BURST beats from the FIFO head
    // B      | waiting for the write response, then advance the ring
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    localparam int BYTES = BURST * DW / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;

    logic [1:0]    state;
    logic          en_q;
    logic          start;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic          full_q;
    logic          push;
    logic          pop;
    logic [BW-1:0] beat_left;
    logic [24:0]   acnt_nxt;

    assign start     = en & ~en_q;
    assign s_ready   = en & ~full_q;
    assign push      = s_valid & s_ready;
    assign pop       = wvalid & wready;
    assign level     = wr_ptr - rd_ptr;
    assign level_nxt = level + LW'(push) - LW'(pop);
    assign acnt_nxt  = {1'b0, acnt} + 25'(BYTES);

    assign awlen   = 4'(BURST - 1);
    assign awsize  = 3'($clog2(DW / 8));
    assign awburst = 2'b01;
    assign awid    = AXI_ID;
    assign wstrb   = '1;
    assign wvalid  = (state == S_W);
    assign wlast   = wvalid && (beat_left == '0);
    assign bready  = (state == S_B);
    assign busy    = (state != S_IDLE);
    // Gated so the data bus reads zero outside the W phase.
    assign wdata   = wvalid ? mem[rd_ptr[PW-1:0]] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    // A sample accepted in the restart cycle lands in slot 0 of the
    // freshly cleared FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[start ? '0 : wr_ptr[PW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else if (start) begin
            wr_ptr <= {{PW{1'b0}}, push};
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LW'(1);
            if (pop)  rd_ptr <= rd_ptr + LW'(1);
            full_q <= (level_nxt == LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovf_cnt <= '0;
        end else if (start) begin
            ovf_cnt <= '0;
        end else if (s_valid && en && full_q && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            beat_left <= '0;
            acnt      <= '0;
            bcnt      <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // No launch in the restart cycle: level still reflects
                    // the FIFO contents that are being discarded.
                    if (en && !start && (level >= LW'(BURST))) begin
                        awaddr  <= base + {8'd0, acnt};
                        awvalid <= 1'b1;
                        state   <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid   <= 1'b0;
                        beat_left <= BW'(BURST - 1);
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (beat_left == '0) begin
                            state <= S_B;
                        end else begin
                            beat_left <= beat_left - BW'(1);
                        end
                    end
                end
                default: begin
                    if (bvalid) begin
                        state <= S_IDLE;
                        if (bresp != 2'b00) resp_err <= 1'b1;
                        // Also covers size smaller than one burst (incl. 0):
                        // offset stays 0 and every burst counts as a wrap.
                        if (acnt_nxt >= {1'b0, size}) begin
                            acnt <= '0;
                            bcnt <= bcnt + 32'd1;
                        end else begin
                            acnt <= acnt_nxt[23:0];
                        end
                    end
                end
            endcase
            if (start) begin
                acnt     <= '0;
                bcnt     <= '0;
                resp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_ring_wr_dma.sv
module tb_axi_ring_wr_dma;

    localparam int DW    = 32;
    localparam int BURST = 16;
    localparam int DEPTH = 64;
    localparam int BYTES = BURST * DW / 8;

    logic        clk;
    logic        nrst;

    logic        en;
    logic [31:0] base;
    logic [23:0] size;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [5:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [23:0] acnt;
    logic [31:0] bcnt;
    logic [15:0] ovf_cnt;
    logic        resp_err;
    logic        busy;

    logic        en6;
    logic [31:0] base6;
    logic [23:0] size6;
    logic [63:0] s6_data;
    logic        s6_valid;
    logic        s6_ready;
    logic [31:0] aw6addr;
    logic [3:0]  aw6len;
    logic [2:0]  aw6size;
    logic [1:0]  aw6burst;
    logic [5:0]  aw6id;
    logic        aw6valid;
    logic        aw6ready;
    logic [63:0] w6data;
    logic [7:0]  w6strb;
    logic        w6last;
    logic        w6valid;
    logic        w6ready;
    logic [1:0]  b6resp;
    logic        b6valid;
    logic        b6ready;
    logic [23:0] acnt6;
    logic [31:0] bcnt6;
    logic [15:0] ovf6;
    logic        resp_err6;
    logic        busy6;

    axi_ring_wr_dma #(.DW(32), .BURST(16), .FIFO_DEPTH(64), .AXI_ID(6'd0)) u_dut (
        .clk(clk), .nrst(nrst), .en(en), .base(base), .size(size),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .acnt(acnt), .bcnt(bcnt), .ovf_cnt(ovf_cnt), .resp_err(resp_err), .busy(busy)
    );

    axi_ring_wr_dma #(.DW(64), .BURST(8), .FIFO_DEPTH(32), .AXI_ID(6'd0)) u_dut64 (
        .clk(clk), .nrst(nrst), .en(en6), .base(base6), .size(size6),
        .s_data(s6_data), .s_valid(s6_valid), .s_ready(s6_ready),
        .awaddr(aw6addr), .awlen(aw6len), .awsize(aw6size), .awburst(aw6burst),
        .awid(aw6id), .awvalid(aw6valid), .awready(aw6ready),
        .wdata(w6data), .wstrb(w6strb), .wlast(w6last), .wvalid(w6valid), .wready(w6ready),
        .bresp(b6resp), .bvalid(b6valid), .bready(b6ready),
        .acnt(acnt6), .bcnt(bcnt6), .ovf_cnt(ovf6), .resp_err(resp_err6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] q[$];
    int          m_level;
    logic        m_en_prev;
    int          n_bursts;
    logic [15:0] m_ovf;
    logic        m_err;
    int          m_beat;
    logic        m_last_push;
    logic [63:0] q6[$];
    int          n6;
    logic        m6_last_push;

    // slave knobs
    int aw_delay;
    int aw_wait;
    int wr_mode;
    int err_burst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ring position after n completed bursts since start.
    function automatic logic [23:0] exp_acnt(input int n, input logic [23:0] sz);
        if (sz < 24'(BYTES)) return 24'd0;
        return 24'((longint'(n) * BYTES) % longint'(sz));
    endfunction

    function automatic logic [31:0] exp_bcnt(input int n, input logic [23:0] sz);
        if (sz < 24'(BYTES)) return 32'(n);
        return 32'((longint'(n) * BYTES) / longint'(sz));
    endfunction

    task automatic monitor();
        logic st, psh, drop, pp;
        logic [63:0] ew;
        chk("s_ready", s_ready, en && (m_level != DEPTH));
        chk("acnt", acnt, exp_acnt(n_bursts, size));
        chk("bcnt", bcnt, exp_bcnt(n_bursts, size));
        chk("ovf_cnt", ovf_cnt, m_ovf);
        chk("resp_err", resp_err, m_err);
        if (awvalid) chk("awaddr", awaddr, base + 32'(exp_acnt(n_bursts, size)));
        if (wvalid) begin
            ew = (q.size() != 0) ? {32'd0, q[0]} : 'x;
            chk("wdata", wdata, ew);
            chk("wlast", wlast, m_beat == BURST - 1);
        end

        st   = en && !m_en_prev;
        m_en_prev = en;
        pp   = wvalid && wready;
        psh  = s_valid && en && (m_level != DEPTH);
        drop = s_valid && en && (m_level == DEPTH);
        m_last_push = psh;
        if (st) begin
            q.delete();
            m_level = 0;
            m_ovf   = 16'd0;
            m_err   = 1'b0;
            n_bursts = 0;
        end else begin
            if (pp) begin
                void'(q.pop_front());
                m_level--;
                m_beat++;
            end
            if (drop && m_ovf != 16'hFFFF) m_ovf++;
        end
        if (psh) begin
            q.push_back(s_data);
            m_level++;
        end
        if (bvalid && bready) begin
            chk("beats_per_burst", m_beat, BURST);
            m_beat = 0;
            if (!st) begin
                if (bresp != 2'b00) m_err = 1'b1;
                n_bursts++;
            end
        end

        chk("acnt6", acnt6, 24'd0);
        chk("bcnt6", bcnt6, n6);
        if (aw6valid) begin
            chk("awaddr6", aw6addr, base6);
            chk("awlen6", aw6len, 4'd7);
            chk("awsize6", aw6size, 3'd3);
        end
        if (w6valid) begin
            ew = (q6.size() != 0) ? q6[0] : 'x;
            chk("wdata6", w6data, ew);
            if (w6ready) void'(q6.pop_front());
        end
        m6_last_push = s6_valid && s6_ready;
        if (m6_last_push) q6.push_back(s6_data);
        if (b6valid && b6ready) n6++;
    endtask

    task automatic slave_drive();
        if (awvalid) begin
            awready = (aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            awready = 1'b0;
            aw_wait = 0;
        end
        case (wr_mode)
            0: wready = 1'b1;
            1: wready = !wready;
            2: wready = 1'b0;
            default: wready = 1'($urandom_range(0, 1));
        endcase
        bvalid = bready;
        bresp  = (bready && n_bursts == err_burst) ? 2'b10 : 2'b00;
        aw6ready = 1'b1;
        w6ready  = 1'b1;
        b6valid  = b6ready;
        b6resp   = 2'b00;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        slave_drive();
    endtask

    task automatic send(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 3000) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
            if (m_last_push) got++;
            guard++;
        end
        s_valid = 1'b0;
        chk("send_done", got, n);
    endtask

    task automatic drive_raw(input int n);
        repeat (n) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int g = 0;
        while ((busy || (en && m_level >= BURST)) && g < max) begin
            tick();
            g++;
        end
        chk("drain_done", {busy, en && (m_level >= BURST)}, 2'b00);
    endtask

    initial begin
        int g;
        nrst = 1'b0;
        en = 1'b0; base = 32'h1000_0000; size = 24'h400;
        s_data = '0; s_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        en6 = 1'b0; base6 = 32'h2000_0000; size6 = 24'd0;
        s6_data = '0; s6_valid = 1'b0;
        aw6ready = 1'b0; w6ready = 1'b0; b6resp = 2'b00; b6valid = 1'b0;
        q.delete(); q6.delete();
        m_level = 0; m_en_prev = 1'b0; n_bursts = 0; m_ovf = '0; m_err = 1'b0;
        m_beat = 0; m_last_push = 1'b0; n6 = 0; m6_last_push = 1'b0;
        aw_delay = 0; aw_wait = 0; wr_mode = 0; err_burst = -1;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_bready", bready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_acnt", acnt, 0);
        chk("rst_bcnt", bcnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_awlen", awlen, 4'd15);
        chk("rst_awsize", awsize, 3'd2);
        chk("rst_awburst", awburst, 2'b01);
        chk("rst_awid", awid, 6'd0);
        chk("rst_wstrb", wstrb, 4'hF);
        chk("rst_awsize6", aw6size, 3'd3);
        chk("rst_awlen6", aw6len, 4'd7);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        slave_drive();

        // 1: 256 words, ready slave -> 16 bursts, one wrap
        en = 1'b1;
        send(256);
        wait_drain(600);
        chk("t1_bursts", n_bursts, 16);
        chk("t1_acnt", acnt, 24'd0);
        chk("t1_bcnt", bcnt, 32'd1);

        // 2: slow awready, toggling wready
        aw_delay = 5;
        wr_mode  = 1;
        send(16);
        wait_drain(300);
        chk("t2_bursts", n_bursts, 17);
        chk("t2_acnt", acnt, 24'h040);
        aw_delay = 0;

        // 3: FIFO full with wready low, 10 dropped samples
        en = 1'b0; tick();
        en = 1'b1; tick();
        wr_mode = 2;
        send(64);
        drive_raw(10);
        chk("t3_ovf", ovf_cnt, 16'd10);
        chk("t3_s_ready", s_ready, 1'b0);
        wr_mode = 0;
        wait_drain(300);
        chk("t3_bursts", n_bursts, 4);
        chk("t3_ovf_hold", ovf_cnt, 16'd10);

        // 4: error response on the second burst
        en = 1'b0; tick();
        en = 1'b1; tick();
        err_burst = 1;
        send(48);
        wait_drain(300);
        chk("t4_resp_err", resp_err, 1'b1);
        chk("t4_acnt", acnt, 24'h0C0);
        err_burst = -1;
        en = 1'b0; tick(); tick();
        chk("t4_err_held", resp_err, 1'b1);
        en = 1'b1; tick();
        chk("t4_err_cleared", resp_err, 1'b0);

        // 5: en dropped at beat 7, residue kept until restart
        send(21);
        g = 0;
        while (!(wvalid && m_beat == 7) && g < 200) begin
            tick();
            g++;
        end
        chk("t5_beat7", m_beat, 7);
        en = 1'b0;
        g = 0;
        while (busy && g < 100) begin
            tick();
            g++;
        end
        chk("t5_idle", busy, 1'b0);
        chk("t5_bursts", n_bursts, 1);
        drive_raw(3);
        repeat (20) tick();
        chk("t5_stays_idle", busy, 1'b0);
        chk("t5_ovf_en0", ovf_cnt, 16'd0);
        en = 1'b1; tick();
        chk("t5_acnt_restart", acnt, 24'd0);
        send(16);
        wait_drain(200);
        chk("t5_bursts_after", n_bursts, 1);

        // random mix of stalls
        wr_mode  = 3;
        aw_delay = 2;
        send(80);
        wait_drain(600);
        chk("rand_bursts", n_bursts, 6);
        wr_mode  = 0;
        aw_delay = 0;

        // 6: 64-bit, 8-beat, size 0
        en6 = 1'b1;
        g = 0;
        while (g < 32) begin
            s6_valid = 1'b1;
            s6_data  = {$urandom, $urandom};
            tick();
            if (m6_last_push) g++;
        end
        s6_valid = 1'b0;
        g = 0;
        while ((busy6 || q6.size() >= 8) && g < 200) begin
            tick();
            g++;
        end
        chk("t6_idle", busy6, 1'b0);
        chk("t6_bcnt", bcnt6, 32'd4);
        chk("t6_awsize", aw6size, 3'd3);
        chk("t6_awlen", aw6len, 4'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
